// File: rtl/axilite_trng_fifo.sv
// ---------------------------------------------------------------------------
// axilite_trng_fifo
//
// AXI4-Lite slave that packs a raw multi-channel entropy bit stream into
// 32-bit words, buffers them in a FIFO and serves them through a read-only
// DATA register. It also provides STATUS, CTRL and THRESH registers, a
// registered level interrupt and a sticky overflow flag.
//
// Register map (addr[3:2]):
//   0x0 DATA    RO  pop FIFO head; empty FIFO -> RDATA=0, RRESP=SLVERR
//   0x4 STATUS  RO  [0]=empty [1]=full [2]=overflow [15:8]=count
//   0x8 CTRL    RW  [0]=enable [1]=irq_en [2]=flush (pulse) [3]=ovf_clr (pulse)
//   0xC THRESH  RW  [7:0] interrupt level threshold
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN   clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   AXI4-Lite write address/data/response
//   S_AXI_AR* / S_AXI_R*              AXI4-Lite read address/data
//   ENTROPY_BITS [C_NUM_CH-1:0]       raw entropy sample
//   ENTROPY_VALID                     sample valid this cycle
//   IRQ                               registered level interrupt
// ---------------------------------------------------------------------------
module axilite_trng_fifo #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_FIFO_DEPTH       = 16,
    parameter int C_NUM_CH           = 4,
    parameter int C_IRQ_THRESH       = 8
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [C_NUM_CH-1:0]               ENTROPY_BITS,
    input  logic                              ENTROPY_VALID,
    output logic                              IRQ
);

    localparam int SAMPLES = 32 / C_NUM_CH;
    localparam int SCNT_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int PTR_W   = $clog2(C_FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    // AXI handshake state
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        irq;

    // Register file
    logic        enable;
    logic        irq_en;
    logic [7:0]  thresh;
    logic        ovf;

    // Packer
    logic [31:0]       acc;
    logic [31:0]       acc_shift;
    logic [SCNT_W-1:0] sample_cnt;
    logic              sample_last;
    logic [31:0]       push_data_p1;
    logic              push_vld_p1;

    // FIFO
    logic [31:0]      mem [C_FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             do_push;
    logic             ovf_set;

    // Decode
    logic        wr_fire;
    logic [1:0]  wr_sel;
    logic        ctrl_hit;
    logic        thresh_hit;
    logic        flush;
    logic        ovf_clr;
    logic        rd_fire;
    logic [1:0]  rd_sel;
    logic [31:0] rd_word;
    logic [1:0]  rd_resp;
    logic [31:0] status_word;

    logic unused;
    assign unused = &{1'b0, S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0],
                      S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:8],
                      S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RVALID  = rvalid;
    assign IRQ           = irq;

    // -----------------------------------------------------------------------
    // Write channel: address and data are accepted together; the ready pulse
    // follows the cycle in which both valids were seen with no response
    // pending, and the register update happens on the handshake edge itself.
    // -----------------------------------------------------------------------
    assign wr_fire    = awready & wready & S_AXI_AWVALID & S_AXI_WVALID;
    assign wr_sel     = S_AXI_AWADDR[3:2];
    assign ctrl_hit   = wr_fire && (wr_sel == 2'd2) && S_AXI_WSTRB[0];
    assign thresh_hit = wr_fire && (wr_sel == 2'd3) && S_AXI_WSTRB[0];
    assign flush      = ctrl_hit & S_AXI_WDATA[2];
    assign ovf_clr    = ctrl_hit & S_AXI_WDATA[3];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            // !awready keeps the pulse to a single cycle
            if (S_AXI_AWVALID && S_AXI_WVALID && !bvalid && !awready) begin
                awready <= 1'b1;
                wready  <= 1'b1;
            end else begin
                awready <= 1'b0;
                wready  <= 1'b0;
            end
            if (wr_fire) begin
                bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            enable <= 1'b0;
            irq_en <= 1'b0;
            thresh <= 8'(C_IRQ_THRESH);
        end else begin
            if (ctrl_hit) begin
                enable <= S_AXI_WDATA[0];
                irq_en <= S_AXI_WDATA[1];
            end
            if (thresh_hit) begin
                thresh <= S_AXI_WDATA[7:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Packer: samples shift in LSB-first, so the first sample of a word ends
    // up in the most significant position.
    // -----------------------------------------------------------------------
    generate
        if (C_NUM_CH == 32) begin : g_full_word
            assign acc_shift = ENTROPY_BITS;
        end else begin : g_shift
            assign acc_shift = {acc[31-C_NUM_CH:0], ENTROPY_BITS};
        end
    endgenerate

    assign sample_last = (sample_cnt == SCNT_W'(SAMPLES - 1));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            acc          <= '0;
            sample_cnt   <= '0;
            push_data_p1 <= '0;
            push_vld_p1  <= 1'b0;
        end else if (flush) begin
            // flush discards the partial word and any word waiting to be pushed
            acc         <= '0;
            sample_cnt  <= '0;
            push_vld_p1 <= 1'b0;
        end else begin
            push_vld_p1 <= 1'b0;
            if (enable && ENTROPY_VALID) begin
                acc <= acc_shift;
                if (sample_last) begin
                    sample_cnt   <= '0;
                    push_data_p1 <= acc_shift;
                    push_vld_p1  <= 1'b1;
                end else begin
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

    // --- stage p1: completed word enters the FIFO ---
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(C_FIFO_DEPTH));
    assign pop        = rd_fire && (rd_sel == 2'd0) && !fifo_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push    = push_vld_p1 && (!fifo_full || pop) && !flush;
    assign ovf_set    = push_vld_p1 && fifo_full && !pop && !flush;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (do_push) begin
            mem[wptr] <= push_data_p1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Read channel: the DATA pop and the RDATA capture share the handshake
    // edge. Data comes from the pre-edge FIFO state, so a read on a flush
    // edge still returns the old head.
    // -----------------------------------------------------------------------
    assign rd_fire     = arready & S_AXI_ARVALID;
    assign rd_sel      = S_AXI_ARADDR[3:2];
    assign status_word = {16'd0, 8'(count), 5'd0, ovf, fifo_full, fifo_empty};

    always_comb begin
        rd_word = '0;
        rd_resp = 2'b00;
        case (rd_sel)
            2'd0: begin
                if (fifo_empty) begin
                    rd_resp = 2'b10;
                end else begin
                    rd_word = mem[rptr];
                end
            end
            2'd1:    rd_word = status_word;
            2'd2:    rd_word = {30'd0, irq_en, enable};
            default: rd_word = {24'd0, thresh};
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            arready <= S_AXI_ARVALID && !rvalid && !arready;
            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
                rresp  <= rd_resp;
            end else if (S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Interrupt is computed from registered state, so it lags count by one cycle
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & ((9'(count) >= {1'b0, thresh}) | ovf);
        end
    end

endmodule

// File: tb/tb_axilite_trng_fifo.sv
// ---------------------------------------------------------------------------
// Self-checking bench for axilite_trng_fifo. A queue-based reference model
// tracks the FIFO contents, the partial word, the control registers and the
// overflow flag; directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_axilite_trng_fifo;

    localparam int DEPTH = 16;
    localparam int NCH   = 4;
    localparam int SPW   = 32 / NCH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [NCH-1:0] ENTROPY_BITS;
    logic        ENTROPY_VALID;
    logic        IRQ;

    always #5 clk = ~clk;

    axilite_trng_fifo #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_FIFO_DEPTH(DEPTH),
        .C_NUM_CH(NCH),
        .C_IRQ_THRESH(8)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA),
        .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA),
        .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .ENTROPY_BITS(ENTROPY_BITS),
        .ENTROPY_VALID(ENTROPY_VALID),
        .IRQ(IRQ)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int          mpend[$];
    bit          m_en;
    bit          m_irq_en;
    bit          m_ovf;
    int          m_thresh;

    function automatic void m_reset();
        mq.delete();
        mpend.delete();
        m_en = 0;
        m_irq_en = 0;
        m_ovf = 0;
        m_thresh = 8;
    endfunction

    function automatic void m_push(input logic [31:0] w);
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovf = 1;
    endfunction

    function automatic void m_sample(input int b);
        logic [63:0] w;
        if (!m_en) return;
        mpend.push_back(b);
        if (mpend.size() == SPW) begin
            w = 0;
            foreach (mpend[k]) w = (w << NCH) | 64'(mpend[k]);
            mpend.delete();
            m_push(w[31:0]);
        end
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size()) * 256;
        if (m_ovf) s = s + 4;
        if (mq.size() == DEPTH) s = s + 2;
        if (mq.size() == 0) s = s + 1;
        return s;
    endfunction

    function automatic logic m_irq();
        return m_irq_en && ((mq.size() >= m_thresh) || m_ovf);
    endfunction

    function automatic void m_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb);
        if (!strb[0]) return;
        if (addr[3:2] == 2'd2) begin
            m_en = d[0];
            m_irq_en = d[1];
            if (d[2]) begin
                mq.delete();
                mpend.delete();
            end
            if (d[3]) m_ovf = 0;
        end else if (addr[3:2] == 2'd3) begin
            m_thresh = int'(d[7:0]);
        end
    endfunction

    function automatic void m_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        d = 0;
        r = 2'b00;
        case (addr[3:2])
            2'd0: begin
                if (mq.size() == 0) r = 2'b10;
                else d = mq.pop_front();
            end
            2'd1: d = m_status();
            2'd2: d = {30'd0, m_irq_en, m_en};
            default: d = 32'(m_thresh);
        endcase
    endfunction

    // ---------------- drivers (all start and end #1 after an edge) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sample(input logic [NCH-1:0] b, input bit v);
        ENTROPY_BITS = b;
        ENTROPY_VALID = v;
        @(posedge clk);
        #1;
        ENTROPY_VALID = 0;
        if (v) m_sample(int'(b));
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb);
        int n;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA = d;
        S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1;
        S_AXI_WVALID = 1;
        S_AXI_BREADY = 0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!S_AXI_AWREADY && n < 20);
        if (!S_AXI_AWREADY) begin
            chk("aw_timeout", 0, 1);
            S_AXI_AWVALID = 0;
            S_AXI_WVALID = 0;
            return;
        end
        chk("wready_with_awready", 32'(S_AXI_WREADY), 1);
        @(posedge clk);
        #1;
        m_write(addr, d, strb);
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 0;
        chk("bvalid", 32'(S_AXI_BVALID), 1);
        chk("bresp", 32'(S_AXI_BRESP), 0);
        S_AXI_BREADY = 1;
        @(posedge clk);
        #1;
        S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input bit inject, input logic [NCH-1:0] bits,
                            output logic [31:0] d, output logic [1:0] r);
        int n;
        d = 0;
        r = 0;
        S_AXI_ARADDR = addr;
        S_AXI_ARVALID = 1;
        S_AXI_RREADY = 0;
        if (inject) begin
            ENTROPY_BITS = bits;
            ENTROPY_VALID = 1;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            ENTROPY_VALID = 0;
            n++;
        end while (!S_AXI_ARREADY && n < 20);
        if (!S_AXI_ARREADY) begin
            chk("ar_timeout", 0, 1);
            S_AXI_ARVALID = 0;
            return;
        end
        @(posedge clk);
        #1;
        S_AXI_ARVALID = 0;
        chk("rvalid", 32'(S_AXI_RVALID), 1);
        d = S_AXI_RDATA;
        r = S_AXI_RRESP;
        S_AXI_RREADY = 1;
        @(posedge clk);
        #1;
        S_AXI_RREADY = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input bit inject, input logic [NCH-1:0] bits);
        logic [31:0] ed, d;
        logic [1:0]  er, r;
        m_read(addr, ed, er);
        axi_read(addr, inject, bits, d, r);
        if (inject) m_sample(int'(bits));
        chk({tag, "_data"}, d, ed);
        chk({tag, "_resp"}, 32'(r), 32'(er));
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_ctl"}, 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                                S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, IRQ}), 0);
        chk({tag, "_rdata"}, S_AXI_RDATA, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          n, op;

        S_AXI_AWADDR = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0;
        S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = 0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 0; ENTROPY_BITS = 0; ENTROPY_VALID = 0;
        m_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        outs_zero("reset");
        rst_n = 1;
        idle(2);
        rd_chk("rst_status", 32'h4, 0, 0);
        rd_chk("rst_ctrl", 32'h8, 0, 0);
        rd_chk("rst_thresh", 32'hC, 0, 0);
        chk("rst_irq", 32'(IRQ), 0);

        // packing 0x1..0x8 -> 0x12345678
        axi_write(32'h8, 32'h1, 4'hF);
        for (int i = 1; i <= 8; i++) send_sample(NCH'(i), 1);
        rd_chk("t1_status", 32'h4, 0, 0);
        m_read(32'h0, ed, er);
        axi_read(32'h0, 0, 0, d, r);
        chk("t1_word", d, 32'h12345678);
        chk("t1_resp", 32'(r), 0);

        // empty read
        axi_read(32'h0, 0, 0, d, r);
        m_read(32'h0, ed, er);
        chk("t2_empty_data", d, 0);
        chk("t2_empty_resp", 32'(r), 2);
        axi_read(32'h4, 0, 0, d, r);
        chk("t2_status", d, 32'h1);

        // fill, overflow, overflow clear
        for (int w = 0; w < DEPTH + 1; w++)
            for (int k = 0; k < SPW; k++) send_sample(NCH'($urandom), 1);
        axi_read(32'h4, 0, 0, d, r);
        chk("t3_full_ovf", d, 32'h1006);
        rd_chk("t3_model_status", 32'h4, 0, 0);
        axi_write(32'h8, 32'h9, 4'hF);
        rd_chk("t3_ovf_clr", 32'h4, 0, 0);

        // push and pop in the same cycle while full
        for (int k = 0; k < SPW - 1; k++) send_sample(NCH'($urandom), 1);
        rd_chk("t6_pushpop", 32'h0, 1, NCH'($urandom));
        axi_read(32'h4, 0, 0, d, r);
        chk("t6_status", d, 32'h1002);
        for (int i = 0; i < DEPTH; i++) rd_chk("t6_drain", 32'h0, 0, 0);
        rd_chk("t6_empty", 32'h0, 0, 0);

        // flush drops a partial word; enable=0 keeps one
        for (int k = 0; k < 4; k++) send_sample(NCH'($urandom), 1);
        axi_write(32'h8, 32'h5, 4'hF);
        for (int k = 0; k < 3; k++) send_sample(NCH'($urandom), 1);
        axi_write(32'h8, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) send_sample(NCH'($urandom), 1);
        axi_write(32'h8, 32'h1, 4'hF);
        for (int k = 0; k < 5; k++) send_sample(NCH'($urandom), 1);
        rd_chk("flush_status", 32'h4, 0, 0);
        rd_chk("flush_word", 32'h0, 0, 0);

        // interrupt threshold
        axi_write(32'hC, 32'h2, 4'hF);
        axi_write(32'h8, 32'h3, 4'hF);
        for (int k = 0; k < 2 * SPW; k++) send_sample(NCH'($urandom), 1);
        @(posedge clk); #1;
        chk("t4_irq_lag", 32'(IRQ), 0);
        @(posedge clk); #1;
        chk("t4_irq_set", 32'(IRQ), 1);
        rd_chk("t4_pop", 32'h0, 0, 0);
        idle(1);
        chk("t4_irq_clr", 32'(IRQ), 0);
        rd_chk("t4_pop2", 32'h0, 0, 0);
        axi_write(32'hC, 32'h0, 4'hF);
        idle(1);
        chk("thresh0_irq", 32'(IRQ), 1);

        // held responses, then reset mid-wait
        S_AXI_AWADDR = 32'h8; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!S_AXI_AWREADY && n < 20);
        chk("t5_awready_seen", 32'(S_AXI_AWREADY), 1);
        @(posedge clk); #1;
        m_write(32'h8, 32'h1, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("t5_bvalid_hold", 32'(S_AXI_BVALID), 1);
            chk("t5_no_awready", 32'(S_AXI_AWREADY), 0);
            @(posedge clk); #1;
        end
        m_read(32'h4, ed, er);
        S_AXI_ARADDR = 32'h4; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!S_AXI_ARREADY && n < 20);
        chk("t5_arready_seen", 32'(S_AXI_ARREADY), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_rvalid_hold", 32'(S_AXI_RVALID), 1);
            chk("t5_no_arready", 32'(S_AXI_ARREADY), 0);
            chk("t5_rdata_hold", S_AXI_RDATA, ed);
            @(posedge clk); #1;
        end
        rst_n = 0;
        #1;
        outs_zero("t5_async_reset");
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        idle(2);
        rst_n = 1;
        m_reset();
        idle(1);
        rd_chk("t5_post_status", 32'h4, 0, 0);
        rd_chk("t5_post_thresh", 32'hC, 0, 0);

        // randomized phase
        axi_write(32'h8, 32'h3, 4'hF);
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                n = $urandom_range(1, 24);
                for (int k = 0; k < n; k++) send_sample(NCH'($urandom), $urandom_range(0, 3) != 0);
                idle(2);
                chk("rnd_irq_ent", 32'(IRQ), 32'(m_irq()));
            end else if (op < 6) begin
                wd = $urandom;
                wd[0] = ($urandom_range(0, 4) != 0);
                wd[2] = ($urandom_range(0, 7) == 0);
                wd[3] = ($urandom_range(0, 3) == 0);
                ws = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) ws[0] = 1;
                axi_write(($urandom & 32'hFFFF_FFF3) | 32'h8, wd, ws);
                idle(1);
                chk("rnd_irq_ctrl", 32'(IRQ), 32'(m_irq()));
            end else if (op == 6) begin
                wd = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 20));
                axi_write(32'hC, wd, 4'($urandom_range(0, 15)));
                idle(1);
                chk("rnd_irq_thr", 32'(IRQ), 32'(m_irq()));
            end else if (op == 7) begin
                axi_write(($urandom & 32'hFFFF_FFF3) | (32'($urandom_range(0, 1)) << 2), $urandom, 4'hF);
            end else begin
                wd = ($urandom & 32'hFFFF_FFF3) |
                     (($urandom_range(0, 2) == 0) ? (32'($urandom_range(1, 3)) << 2) : 32'h0);
                rd_chk("rnd_read", wd, $urandom_range(0, 3) == 0, NCH'($urandom));
                idle(1);
                chk("rnd_irq_rd", 32'(IRQ), 32'(m_irq()));
            end
        end
        rd_chk("final_status", 32'h4, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
